// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns a pipeline control word into one data-memory
// transaction, handling lane alignment, load extension and a response timeout.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for a load/store; misaligned requests rejected here
//   S_ACCESS | strobe held on dmem_* until dmem_resp or timeout
//   S_DONE   | one-cycle result slot; pipeline advances, request not re-taken
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic       TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic [31:0] ldata_q, ldata_d;
  logic        lvalid_q, lvalid_d;
  logic        tmo_q, tmo_d;

  logic        op;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] ld_ext;
  logic        timeout_hit;

  // Width comes from funct3[1:0]; 011/110/111 fall into the word bucket.
  always_comb begin
    op         = req_valid & (mem_read | mem_write);
    is_word    = funct3[1];
    is_half    = (funct3[1:0] == 2'b01);
    misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = store_data;
    if (mem_write) begin
      if (is_word) begin
        req_be    = 4'b1111;
        req_wdata = store_data;
      end else if (is_half) begin
        req_be    = 4'b0011 << addr[1:0];
        req_wdata = {2{store_data[15:0]}};
      end else begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{store_data[7:0]}};
      end
    end
  end

  // Load extraction uses the width/offset captured at issue, not the live inputs.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    case (alo_q)
      2'd0:    b = dmem_rdata[7:0];
      2'd1:    b = dmem_rdata[15:8];
      2'd2:    b = dmem_rdata[23:16];
      default: b = dmem_rdata[31:24];
    endcase
    h = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    if (f3_q[1]) begin
      ld_ext = dmem_rdata;
    end else if (f3_q[0]) begin
      ld_ext = f3_q[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    end else begin
      ld_ext = f3_q[2] ? {24'h000000, b} : {{24{b[7]}}, b};
    end
  end

  // Fires on the ACCESS cycle whose increment would bring the count to the limit.
  always_comb begin
    timeout_hit = TO_EN && (({1'b0, cnt_q} + 9'd1) == TO_LIM);
  end

  always_comb begin
    stall        = (state_q == S_ACCESS) | ((state_q == S_IDLE) & op & ~misaligned);
    misalign_err = (state_q == S_IDLE) & op & misaligned;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    daddr_d  = daddr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    f3_d     = f3_q;
    alo_d    = alo_q;
    ldata_d  = ldata_q;
    lvalid_d = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op && !misaligned) begin
          state_d = S_ACCESS;
          cnt_d   = 8'd0;
          rd_d    = ~mem_write;
          wr_d    = mem_write;
          daddr_d = {addr[31:2], 2'b00};
          wdata_d = req_wdata;
          be_d    = req_be;
          f3_d    = funct3;
          alo_d   = addr[1:0];
        end
      end
      S_ACCESS: begin
        if (dmem_resp) begin
          state_d  = S_DONE;
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          lvalid_d = rd_q;
          if (rd_q) begin
            ldata_d = ld_ext;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ldata_d = 32'h0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      daddr_q  <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      f3_q     <= 3'd0;
      alo_q    <= 2'd0;
      ldata_q  <= 32'h0;
      lvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      daddr_q  <= daddr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      f3_q     <= f3_d;
      alo_q    <= alo_d;
      ldata_q  <= ldata_d;
      lvalid_q <= lvalid_d;
      tmo_q    <= tmo_d;
    end
  end

  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_address     = daddr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign load_data        = ldata_q;
  assign load_valid       = lvalid_q;
  assign timeout_err      = tmo_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (TIMEOUT_CYCLES=4): loads, stores, misalign,
// timeout, resp/timeout race and reset during ACCESS, with hand-computed values.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_err;
  logic        timeout_err;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .stall            (stall),
    .load_data        (load_data),
    .load_valid       (load_valid),
    .misalign_err     (misalign_err),
    .timeout_err      (timeout_err),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd);
    req_valid  = v;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic idle_in();
    drv(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    idle_in();
    nxt();
    nxt();
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_rd", {31'b0, dmem_read}, 32'd0);
    chk("rst_wr", {31'b0, dmem_write}, 32'd0);
    chk("rst_addr", dmem_address, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_be", {28'b0, dmem_byte_enable}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lvalid", {31'b0, load_valid}, 32'd0);
    chk("rst_tmo", {31'b0, timeout_err}, 32'd0);
    rst_n = 1'b1;

    // lb 0x1003, resp one cycle after strobe
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    #2;
    chk("lb_issue_stall", {31'b0, stall}, 32'd1);
    chk("lb_issue_rd", {31'b0, dmem_read}, 32'd0);
    nxt();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h80FF_FFFF;
    #2;
    chk("lb_acc_rd", {31'b0, dmem_read}, 32'd1);
    chk("lb_acc_wr", {31'b0, dmem_write}, 32'd0);
    chk("lb_acc_addr", dmem_address, 32'h0000_1000);
    chk("lb_acc_be", {28'b0, dmem_byte_enable}, 32'hF);
    chk("lb_acc_stall", {31'b0, stall}, 32'd1);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("lb_done_stall", {31'b0, stall}, 32'd0);
    chk("lb_done_lvalid", {31'b0, load_valid}, 32'd1);
    chk("lb_done_ldata", load_data, 32'hFFFF_FF80);
    chk("lb_done_rd", {31'b0, dmem_read}, 32'd0);
    nxt();
    idle_in();
    #2;
    chk("lb_after_rd", {31'b0, dmem_read}, 32'd0);
    chk("lb_after_lvalid", {31'b0, load_valid}, 32'd0);

    // sh 0x2002, resp delayed one extra cycle
    nxt();
    drv(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
    #2;
    chk("sh_issue_stall", {31'b0, stall}, 32'd1);
    nxt();
    #2;
    chk("sh_acc_wr", {31'b0, dmem_write}, 32'd1);
    chk("sh_acc_rd", {31'b0, dmem_read}, 32'd0);
    chk("sh_acc_be", {28'b0, dmem_byte_enable}, 32'hC);
    chk("sh_acc_wdata", dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_acc_addr", dmem_address, 32'h0000_2000);
    nxt();
    dmem_resp = 1'b1;
    #2;
    chk("sh_hold_wr", {31'b0, dmem_write}, 32'd1);
    chk("sh_hold_be", {28'b0, dmem_byte_enable}, 32'hC);
    chk("sh_hold_stall", {31'b0, stall}, 32'd1);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("sh_done_lvalid", {31'b0, load_valid}, 32'd0);
    chk("sh_done_wr", {31'b0, dmem_write}, 32'd0);
    chk("sh_done_stall", {31'b0, stall}, 32'd0);
    nxt();
    idle_in();

    // misaligned requests
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0);
    #2;
    chk("lw_mis_err", {31'b0, misalign_err}, 32'd1);
    chk("lw_mis_stall", {31'b0, stall}, 32'd0);
    nxt();
    #2;
    chk("lw_mis_rd", {31'b0, dmem_read}, 32'd0);
    chk("lw_mis_err2", {31'b0, misalign_err}, 32'd1);
    drv(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h1);
    #1;
    chk("sh_mis_err", {31'b0, misalign_err}, 32'd1);
    drv(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_2002, 32'h0);
    #1;
    chk("f3_011_mis_err", {31'b0, misalign_err}, 32'd1);
    drv(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0);
    #1;
    chk("noval_mis_err", {31'b0, misalign_err}, 32'd0);
    chk("noval_stall", {31'b0, stall}, 32'd0);
    nxt();
    idle_in();
    #2;
    chk("mis_after_rd", {31'b0, dmem_read}, 32'd0);
    chk("mis_after_wr", {31'b0, dmem_write}, 32'd0);

    // timeout: lw, no response, limit 4
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      #2;
      chk($sformatf("tmo_rd_c%0d", i), {31'b0, dmem_read}, 32'd1);
      chk($sformatf("tmo_err_c%0d", i), {31'b0, timeout_err}, 32'd0);
    end
    nxt();
    #2;
    chk("tmo_done_rd", {31'b0, dmem_read}, 32'd0);
    chk("tmo_done_err", {31'b0, timeout_err}, 32'd1);
    chk("tmo_done_ldata", load_data, 32'h0);
    chk("tmo_done_lvalid", {31'b0, load_valid}, 32'd0);
    chk("tmo_done_stall", {31'b0, stall}, 32'd0);
    nxt();
    idle_in();
    #2;
    chk("tmo_after_err", {31'b0, timeout_err}, 32'd0);
    chk("tmo_after_rd", {31'b0, dmem_read}, 32'd0);

    // lh 0x6002: resp on the 4th ACCESS cycle wins over timeout
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0);
    nxt();
    nxt();
    nxt();
    nxt();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h8765_4321;
    #2;
    chk("race_rd", {31'b0, dmem_read}, 32'd1);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("race_lvalid", {31'b0, load_valid}, 32'd1);
    chk("race_tmo", {31'b0, timeout_err}, 32'd0);
    chk("race_ldata", load_data, 32'hFFFF_8765);
    nxt();
    idle_in();

    // lhu 0x0002 with reset the cycle before resp
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
    nxt();
    idle_in();
    rst_n = 1'b0;
    #2;
    chk("rstacc_rd", {31'b0, dmem_read}, 32'd1);
    nxt();
    rst_n      = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hABCD_1234;
    #2;
    chk("rstacc_rd_drop", {31'b0, dmem_read}, 32'd0);
    chk("rstacc_stall", {31'b0, stall}, 32'd0);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("rstacc_lvalid", {31'b0, load_valid}, 32'd0);
    chk("rstacc_ldata", load_data, 32'h0);
    chk("rstacc_rd2", {31'b0, dmem_read}, 32'd0);

    // sb with both strobes set: store wins
    nxt();
    drv(1'b1, 1'b1, 1'b1, 3'b000, 32'h0000_5001, 32'h0000_005A);
    nxt();
    dmem_resp = 1'b1;
    #2;
    chk("sb_wr", {31'b0, dmem_write}, 32'd1);
    chk("sb_rd", {31'b0, dmem_read}, 32'd0);
    chk("sb_be", {28'b0, dmem_byte_enable}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", dmem_address, 32'h0000_5000);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("sb_lvalid", {31'b0, load_valid}, 32'd0);
    nxt();
    idle_in();
    dmem_resp = 1'b1;
    #2;
    chk("idle_resp_stall", {31'b0, stall}, 32'd0);
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("idle_resp_lvalid", {31'b0, load_valid}, 32'd0);

    // sw passthrough, then lbu zero-extension
    drv(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_8004, 32'hDEAD_BEEF);
    nxt();
    dmem_resp = 1'b1;
    #2;
    chk("sw_be", {28'b0, dmem_byte_enable}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    nxt();
    dmem_resp = 1'b0;
    nxt();
    drv(1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_7001, 32'h0);
    nxt();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1234_80AB;
    nxt();
    dmem_resp = 1'b0;
    #2;
    chk("lbu_lvalid", {31'b0, load_valid}, 32'd1);
    chk("lbu_ldata", load_data, 32'h0000_0080);
    nxt();
    idle_in();
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ACCESS cycles allowed before abort; 0 disables timeout; legal range 0..255.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  MEM-stage control word valid.
REQ-005 mem_read  in  1  control word load request.
REQ-006 mem_write  in  1  control word store request.
REQ-007 funct3  in  3  load/store width code (lb/lh/lw/lbu/lhu, sb/sh/sw encodings).
REQ-008 addr  in  32  byte address from ALU.
REQ-009 store_data  in  32  rs2 value.
REQ-010 stall  out  1  hold the pipeline this cycle.
REQ-011 load_data  out  32  extended load result.
REQ-012 load_valid  out  1  load_data valid (one-cycle pulse).
REQ-013 misalign_err  out  1  misaligned access rejected.
REQ-014 timeout_err  out  1  access aborted by timeout (one-cycle pulse).
REQ-015 dmem_read, dmem_write  out  1 each  data-memory strobes.
REQ-016 dmem_address  out  32  word-aligned address, bits [1:0] = 0.
REQ-017 dmem_wdata  out  32  lane-replicated store data.
REQ-018 dmem_byte_enable  out  4  byte lane mask.
REQ-019 dmem_rdata  in  32  read data, valid with dmem_resp.
REQ-020 dmem_resp  in  1  memory completion.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; all dmem_* outputs and load_data are registered.
REQ-022 op = req_valid & (mem_read | mem_write); if both strobes are set, perform a store and ignore the read.
REQ-023 Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0; funct3 011/110/111 are treated as word.
REQ-024 IDLE, op and aligned: latch address, data, lanes and funct3; go to ACCESS; stall=1.
REQ-025 IDLE, op and misaligned: misalign_err=1 combinationally, stall=0, no memory access, remain IDLE.
REQ-026 IDLE, no op: stall=0; all strobes 0.
REQ-027 ACCESS: exactly one of dmem_read/dmem_write=1; address, wdata and byte_enable stay constant; stall=1.
REQ-028 ACCESS with dmem_resp=1: register the load result when reading; clear strobes; go to DONE; stall=1 that cycle.
REQ-029 DONE: stall=0; load_valid=1 for a completed load only; inputs ignored; next state IDLE. DONE prevents re-issuing the same instruction.
REQ-030 Minimum latency: request in IDLE at cycle N, strobe at N+1; if resp arrives at N+1, DONE is at N+2 and the pipeline advances at the end of N+2.
REQ-031 Byte enables: sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111; all loads 1111.
REQ-032 wdata: sb replicates byte[7:0] four times; sh replicates [15:0] twice; sw passes through.
REQ-033 Load extract: lb/lbu select byte addr[1:0]; lh/lhu select half addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
REQ-034 An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle without resp.
REQ-035 If TIMEOUT_CYCLES!=0 and count reaches TIMEOUT_CYCLES with no resp: clear strobes, load_data=0, go to DONE, timeout_err=1 in DONE, load_valid=0.
REQ-036 If dmem_resp and the timeout occur in the same cycle, resp wins and there is no error.
REQ-037 dmem_resp outside ACCESS is ignored.

Reset
REQ-038 rst_n=0 at an edge: state IDLE, counter 0, all strobes, enables, address, wdata and load_data 0, all pulse outputs 0.
REQ-039 Reset asserted in ACCESS drops the strobes at that edge; a pending response is discarded.

Verification
REQ-040 lb, addr=0x1003, rdata=0x80FFFFFF, resp 1 cycle after strobe -> byte_enable 1111, dmem_address 0x1000, load_data 0xFFFFFF80, load_valid in DONE, stall 2 cycles.
REQ-041 sh, addr=0x2002, store_data=0x0000BEEF -> dmem_write=1, byte_enable 1100, wdata 0xBEEFBEEF, no load_valid.
REQ-042 lw, addr=0x3001 -> misalign_err=1, stall=0, strobes never assert.
REQ-043 TIMEOUT_CYCLES=4, lw, resp never arrives -> strobe high for 4 cycles, then timeout_err pulse, load_data 0, state returns to IDLE.
REQ-044 lhu, addr=0x0002, rdata=0xABCD1234, rst_n=0 the cycle before resp -> strobes 0 next cycle, no load_valid, IDLE.
REQ-045 mem_read=mem_write=1, sb, addr=0x5001, store_data=0x5A -> write only, byte_enable 0010, wdata 0x5A5A5A5A.
